// File: rtl/instr_queue.sv
// Instruction queue between fetcher and decoder.
// Paces fetch requests, predicts JAL taken, flushes on pipeline clear.
module instr_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear_flag_in,
    input  logic [31:0] clear_pc_in,
    output logic        if_fetch_enable_out,
    input  logic        if_result_enable_in,
    input  logic [31:0] if_instr_in,
    input  logic [31:0] if_pc_in,
    output logic        if_write_pc_sig_out,
    output logic [31:0] if_write_pc_val_out,
    output logic        id_valid_out,
    output logic [31:0] id_instr_out,
    output logic [31:0] id_pc_out,
    output logic        id_pred_jump_out,
    input  logic        id_ready_in,
    output logic        full_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_UPD,
        S_DROP
    } state_t;

    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_LIM = (PTR_W + 1)'(DEPTH - 2);
    localparam logic [PTR_W:0]   CNT_FUL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [6:0]       OP_JAL  = 7'b1101111;

    logic [31:0]      r_mem_instr [DEPTH];
    logic [31:0]      r_mem_pc    [DEPTH];
    logic             r_mem_pred  [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    state_t           r_state;
    logic             r_fetch_en;
    logic             r_wpc_sig;
    logic [31:0]      r_wpc_val;

    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_can_issue;
    logic             w_is_jal;
    logic [31:0]      w_jal_imm;
    logic [31:0]      w_next_pc;
    logic             w_unused;

    assign w_unused    = ^clear_pc_in;

    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid & id_ready_in & rdy & ~clear_flag_in;
    assign w_push      = rdy & ~clear_flag_in & (r_state == S_WAIT)
                       & if_result_enable_in;
    // Registered count only; a same-cycle pop does not open a slot early.
    assign w_can_issue = (r_count <= CNT_LIM);

    assign w_is_jal    = (if_instr_in[6:0] == OP_JAL);
    assign w_jal_imm   = {{11{if_instr_in[31]}}, if_instr_in[31],
                          if_instr_in[19:12], if_instr_in[20],
                          if_instr_in[30:21], 1'b0};
    assign w_next_pc   = w_is_jal ? (if_pc_in + w_jal_imm)
                                  : (if_pc_in + 32'd4);

    assign id_valid_out     = w_valid;
    assign id_instr_out     = w_valid ? r_mem_instr[r_head] : 32'd0;
    assign id_pc_out        = w_valid ? r_mem_pc[r_head]    : 32'd0;
    assign id_pred_jump_out = w_valid ? r_mem_pred[r_head]  : 1'b0;
    assign full_out         = (r_count == CNT_FUL);

    assign if_fetch_enable_out = r_fetch_en;
    assign if_write_pc_sig_out = r_wpc_sig;
    assign if_write_pc_val_out = r_wpc_val;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_tail] <= if_instr_in;
            r_mem_pc[r_tail]    <= if_pc_in;
            r_mem_pred[r_tail]  <= w_is_jal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_fetch_en <= 1'b0;
            r_wpc_sig  <= 1'b0;
            r_wpc_val  <= 32'd0;
        end else if (!rdy) begin
            r_fetch_en <= 1'b0;
            r_wpc_sig  <= 1'b0;
        end else begin
            r_fetch_en <= 1'b0;
            r_wpc_sig  <= 1'b0;
            if (clear_flag_in) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                // A request still in flight must be swallowed later.
                if (r_state == S_WAIT && !if_result_enable_in)
                    r_state <= S_DROP;
                else
                    r_state <= S_IDLE;
            end else begin
                if (w_push)
                    r_tail <= r_tail + PTR_ONE;
                if (w_pop)
                    r_head <= r_head + PTR_ONE;
                if (w_push && !w_pop)
                    r_count <= r_count + CNT_ONE;
                else if (!w_push && w_pop)
                    r_count <= r_count - CNT_ONE;
                unique case (r_state)
                    S_IDLE: begin
                        if (w_can_issue) begin
                            r_fetch_en <= 1'b1;
                            r_state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (if_result_enable_in) begin
                            r_wpc_sig <= 1'b1;
                            r_wpc_val <= w_next_pc;
                            r_state   <= S_UPD;
                        end
                    end
                    S_UPD: begin
                        r_state <= S_IDLE;
                    end
                    S_DROP: begin
                        if (if_result_enable_in)
                            r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed fetch returns,
// decoupled monitors for PC writes and decoder pops.
module tb_instr_queue;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear_flag_in = 1'b0;
    logic [31:0] clear_pc_in = 32'd0;
    logic        if_fetch_enable_out;
    logic        if_result_enable_in = 1'b0;
    logic [31:0] if_instr_in = 32'd0;
    logic [31:0] if_pc_in = 32'd0;
    logic        if_write_pc_sig_out;
    logic [31:0] if_write_pc_val_out;
    logic        id_valid_out;
    logic [31:0] id_instr_out;
    logic [31:0] id_pc_out;
    logic        id_pred_jump_out;
    logic        id_ready_in = 1'b0;
    logic        full_out;

    int n_vec = 0;
    int n_fail = 0;
    int n_fetch = 0;
    int n_served = 0;
    int n_pops = 0;

    ent_t        exp_q[$];
    logic [31:0] wpc_q[$];

    always #5 clk = ~clk;

    instr_queue #(.DEPTH(16), .PTR_W(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .clear_flag_in       (clear_flag_in),
        .clear_pc_in         (clear_pc_in),
        .if_fetch_enable_out (if_fetch_enable_out),
        .if_result_enable_in (if_result_enable_in),
        .if_instr_in         (if_instr_in),
        .if_pc_in            (if_pc_in),
        .if_write_pc_sig_out (if_write_pc_sig_out),
        .if_write_pc_val_out (if_write_pc_val_out),
        .id_valid_out        (id_valid_out),
        .id_instr_out        (id_instr_out),
        .id_pc_out           (id_pc_out),
        .id_pred_jump_out    (id_pred_jump_out),
        .id_ready_in         (id_ready_in),
        .full_out            (full_out)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin
        if (if_fetch_enable_out)
            n_fetch++;
    end

    always @(negedge clk) begin
        if (if_write_pc_sig_out) begin
            if (wpc_q.size() == 0)
                fail_now($sformatf("wpc_unexpected got=%h expected=none",
                                   if_write_pc_val_out));
            else
                chk("wpc_val", if_write_pc_val_out, wpc_q.pop_front());
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (rst && rdy && id_valid_out && id_ready_in && !clear_flag_in) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                fail_now($sformatf("pop_unexpected got=%h expected=none",
                                   id_pc_out));
            end else begin
                e = exp_q.pop_front();
                chk("pop_instr", id_instr_out, e.instr);
                chk("pop_pc", id_pc_out, e.pc);
                chk("pop_pred", {31'd0, id_pred_jump_out}, {31'd0, e.pred});
            end
        end
    end

    // Called at posedge+1; waits for an unserved fetch pulse.
    task automatic wait_req(input int lim, output bit ok);
        int k = 0;
        while (n_fetch == n_served && k < lim) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (n_fetch != n_served);
    endtask

    task automatic fetch_return(input logic [31:0] instr,
                                input logic [31:0] pc,
                                input logic [31:0] nxt,
                                input logic pred);
        bit ok;
        wait_req(100, ok);
        if (!ok) begin
            fail_now("fetch_req_timeout");
        end else begin
            n_served++;
            if_result_enable_in = 1'b1;
            if_instr_in = instr;
            if_pc_in = pc;
            exp_q.push_back('{instr, pc, pred});
            wpc_q.push_back(nxt);
            @(posedge clk);
            #1;
            if_result_enable_in = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        id_ready_in = 1'b1;
        while (id_valid_out && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        id_ready_in = 1'b0;
        if (k >= 100)
            fail_now("drain_timeout");
    endtask

    initial begin
        bit ok;
        int nf;
        int np;
        logic [31:0] hold_pc;

        #1;
        chk("rst_valid", {31'd0, id_valid_out}, 32'd0);
        chk("rst_instr", id_instr_out, 32'd0);
        chk("rst_pc", id_pc_out, 32'd0);
        chk("rst_fetch", {31'd0, if_fetch_enable_out}, 32'd0);
        chk("rst_wpc_sig", {31'd0, if_write_pc_sig_out}, 32'd0);
        chk("rst_wpc_val", if_write_pc_val_out, 32'd0);
        chk("rst_full", {31'd0, full_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        fetch_return(32'h0000_0013, 32'h0, 32'h4, 1'b0);
        fetch_return(32'h0000_0013, 32'h4, 32'h8, 1'b0);
        fetch_return(32'h0000_0013, 32'h8, 32'hC, 1'b0);
        chk("seq_head_pc", id_pc_out, 32'h0);
        chk("seq_head_pred", {31'd0, id_pred_jump_out}, 32'd0);
        np = n_pops;
        drain();
        chk("seq_pop_count", n_pops - np, 3);

        fetch_return(32'h0080_006F, 32'h100, 32'h108, 1'b1);
        fetch_return(32'hFF9F_F06F, 32'h200, 32'h1F8, 1'b1);
        chk("jal_head_pc", id_pc_out, 32'h100);
        chk("jal_head_pred", {31'd0, id_pred_jump_out}, 32'd1);
        drain();

        for (int i = 0; i < 15; i++)
            fetch_return(32'h0000_0013, 32'h1000 + 32'(4 * i),
                         32'h1004 + 32'(4 * i), 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("fill_no_16th", n_fetch - n_served, 0);
        chk("fill_full", {31'd0, full_out}, 32'd0);
        chk("fill_head", id_pc_out, 32'h1000);
        id_ready_in = 1'b1;
        @(posedge clk);
        #1;
        id_ready_in = 1'b0;
        wait_req(10, ok);
        chk("fill_req_after_pop", {31'd0, ok}, 32'd1);
        fetch_return(32'h0000_0013, 32'h2000, 32'h2004, 1'b0);
        np = n_pops;
        drain();
        chk("fill_drain_count", n_pops - np, 15);

        fetch_return(32'h0000_0013, 32'h3000, 32'h3004, 1'b0);
        fetch_return(32'h0000_0013, 32'h3004, 32'h3008, 1'b0);
        fetch_return(32'h0000_0013, 32'h3008, 32'h300C, 1'b0);
        wait_req(100, ok);
        n_served++;
        if_result_enable_in = 1'b1;
        if_instr_in = 32'h0000_0013;
        if_pc_in = 32'h300C;
        id_ready_in = 1'b1;
        exp_q.push_back('{32'h0000_0013, 32'h300C, 1'b0});
        wpc_q.push_back(32'h3010);
        @(posedge clk);
        #1;
        if_result_enable_in = 1'b0;
        id_ready_in = 1'b0;
        chk("pp_head", id_pc_out, 32'h3004);
        np = n_pops;
        drain();
        chk("pp_count", n_pops - np, 3);

        fetch_return(32'h0000_0013, 32'h4000, 32'h4004, 1'b0);
        fetch_return(32'h0000_0013, 32'h4004, 32'h4008, 1'b0);
        wait_req(100, ok);
        clear_flag_in = 1'b1;
        @(posedge clk);
        #1;
        clear_flag_in = 1'b0;
        exp_q.delete();
        chk("clr_valid", {31'd0, id_valid_out}, 32'd0);
        @(posedge clk);
        #1;
        n_served++;
        if_result_enable_in = 1'b1;
        if_instr_in = 32'h0080_006F;
        if_pc_in = 32'h5000;
        @(posedge clk);
        #1;
        if_result_enable_in = 1'b0;
        wait_req(2, ok);
        chk("clr_refetch", {31'd0, ok}, 32'd1);
        chk("clr_stale_dropped", {31'd0, id_valid_out}, 32'd0);
        fetch_return(32'h0000_0013, 32'h6000, 32'h6004, 1'b0);
        chk("clr_new_head", id_pc_out, 32'h6000);

        wait_req(100, ok);
        rdy = 1'b0;
        if_result_enable_in = 1'b1;
        if_instr_in = 32'h0000_0013;
        if_pc_in = 32'h6666;
        nf = n_fetch;
        hold_pc = id_pc_out;
        repeat (5) @(posedge clk);
        #1;
        if_result_enable_in = 1'b0;
        chk("stall_no_fetch", n_fetch - nf, 0);
        chk("stall_hold", id_pc_out, hold_pc);
        rdy = 1'b1;
        fetch_return(32'h0000_0013, 32'h7000, 32'h7004, 1'b0);
        chk("stall_head", id_pc_out, 32'h6000);

        wait_req(100, ok);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, id_valid_out}, 32'd0);
        chk("arst_instr", id_instr_out, 32'd0);
        chk("arst_pc", id_pc_out, 32'd0);
        chk("arst_pred", {31'd0, id_pred_jump_out}, 32'd0);
        chk("arst_fetch", {31'd0, if_fetch_enable_out}, 32'd0);
        chk("arst_wpc_val", if_write_pc_val_out, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_result_enable_in = 1'b1;
        if_instr_in = 32'h0000_0013;
        if_pc_in = 32'h8000;
        @(posedge clk);
        #1;
        if_result_enable_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_late_ignored", {31'd0, id_valid_out}, 32'd0);
        chk("arst_wpc_left", wpc_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
